// File: rtl/divekick_pkg.sv
// Shared command/state encodings and default sizing for the divekick input controller.
package divekick_pkg;

  localparam int unsigned CMD_W            = 2;
  localparam int unsigned DEFAULT_COOLDOWN = 8;
  localparam int unsigned DEFAULT_CNT_W    = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE = 2'b00,
    CMD_DIVE = 2'b01,
    CMD_KICK = 2'b10
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    COOL
  } pstate_t;

endpackage

// File: rtl/divekick_input_ctrl_if.sv
// Key flags in, per-player valid/ack command handshakes out.
interface divekick_input_ctrl_if;
  import divekick_pkg::*;

  logic frame_tick;
  logic game_active;
  logic a_on;
  logic s_on;
  logic k_on;
  logic l_on;
  logic p1_valid;
  cmd_t p1_cmd;
  logic p1_ack;
  logic p2_valid;
  cmd_t p2_cmd;
  logic p2_ack;
  logic p1_busy;
  logic p2_busy;

  // Controller side
  modport slave (
    input  frame_tick, game_active, a_on, s_on, k_on, l_on, p1_ack, p2_ack,
    output p1_valid, p1_cmd, p2_valid, p2_cmd, p1_busy, p2_busy
  );

  // Decoder / consumer side
  modport master (
    output frame_tick, game_active, a_on, s_on, k_on, l_on, p1_ack, p2_ack,
    input  p1_valid, p1_cmd, p2_valid, p2_cmd, p1_busy, p2_busy
  );

endinterface

// File: rtl/divekick_player_fsm.sv
// One fighter's press-to-command logic: key registers, issue/hold/cooldown FSM and
// the valid/ack handshake towards the motion logic.
module divekick_player_fsm
  import divekick_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = DEFAULT_COOLDOWN,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic game_active,
  input  logic dive_key,
  input  logic kick_key,
  input  logic ack,
  output logic valid,
  output cmd_t cmd,
  output logic busy
);

  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);

  logic             dive_q;
  logic             kick_q;
  logic             key_any;
  pstate_t          state;
  pstate_t          state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             valid_n;
  cmd_t             cmd_n;

  assign key_any = dive_q | kick_q;

  // Single input register stage; every decision below looks at the registered keys.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dive_q <= 1'b0;
      kick_q <= 1'b0;
    end else begin
      dive_q <= dive_key;
      kick_q <= kick_key;
    end
  end

  // Reset lands in HOLD so a key held through reset must be released first.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= HOLD;
      cnt   <= '0;
      valid <= 1'b0;
      cmd   <= CMD_NONE;
      busy  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      valid <= valid_n;
      cmd   <= cmd_n;
      busy  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid;
    cmd_n   = cmd;
    unique case (state)
      IDLE: begin
        if (frame_tick && game_active && key_any) begin
          cmd_n   = dive_q ? CMD_DIVE : CMD_KICK;
          valid_n = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // Ack consumes; losing game_active discards. Either way wait for release.
        if (ack || !game_active) begin
          valid_n = 1'b0;
          cmd_n   = CMD_NONE;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (frame_tick && !key_any) begin
          if (COOLDOWN_FRAMES == 0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = COOL_LOAD;
            state_n = COOL;
          end
        end
      end
      COOL: begin
        if (key_any) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else if (cnt == '0) begin
          state_n = IDLE;
        end else if (frame_tick) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt_n == '0) state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        cmd_n   = CMD_NONE;
        state_n = HOLD;
      end
    endcase
  end

endmodule

// File: rtl/divekick_input_ctrl.sv
// Two independent player command generators: P1 on a/s keys, P2 on k/l keys.
module divekick_input_ctrl #(
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  divekick_input_ctrl_if.slave  bus
);

  divekick_player_fsm #(
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
    .CNT_W           (CNT_W)
  ) u_p1 (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (bus.frame_tick),
    .game_active (bus.game_active),
    .dive_key    (bus.a_on),
    .kick_key    (bus.s_on),
    .ack         (bus.p1_ack),
    .valid       (bus.p1_valid),
    .cmd         (bus.p1_cmd),
    .busy        (bus.p1_busy)
  );

  divekick_player_fsm #(
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
    .CNT_W           (CNT_W)
  ) u_p2 (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (bus.frame_tick),
    .game_active (bus.game_active),
    .dive_key    (bus.k_on),
    .kick_key    (bus.l_on),
    .ack         (bus.p2_ack),
    .valid       (bus.p2_valid),
    .cmd         (bus.p2_cmd),
    .busy        (bus.p2_busy)
  );

endmodule
